maze_move_replay: RTL and testbench

Move-path recorder and replay controller for the 16x16 maze solver. During a solve it records the solver's DFS move stack (push on advance, pop on backtrack); once the solver reports success, each `run` pulse replays the recorded path from the maze entry to the exit, one move per step interval. It sits between the solver core and the downstream move consumer and owns the only copy of the final path.

---
 rtl/maze_pkg.sv | 24 ++
 rtl/move_stack.sv | 74 +++++++
 rtl/maze_move_replay.sv | 154 +++++++++++++++
 tb/tb_maze_move_replay.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze move recorder/replayer.
// PAUSE exists only when MAZE_REPLAY_PAUSE_EN is defined.
package maze_pkg;

  localparam int unsigned MAZE_CELLS = 256;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    LEFT  = 2'b11
  } move_t;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    READY,
    PLAY
`ifdef MAZE_REPLAY_PAUSE_EN
    , PAUSE
`endif
  } replay_state_t;

endpackage

// File: rtl/move_stack.sv
// DFS move stack: push / pop / replace-top with sticky overflow and underflow flags,
// plus a combinational indexed read port used for replay.
module move_stack
  import maze_pkg::*;
#(
  parameter int unsigned DEPTH = MAZE_CELLS,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  move_t         wdata,
  input  logic [AW-1:0] raddr,
  output move_t         rdata,
  output logic [AW:0]   depth,
  output logic          err_overflow,
  output logic          err_underflow
);

  move_t mem [DEPTH];

  logic          empty;
  logic          full;
  logic          do_replace;
  logic          do_push;
  logic          do_pop;
  logic          ovf_hit;
  logic          unf_hit;
  logic          wr_en;
  logic [AW:0]   wptr;

  // Push together with pop replaces the top entry; on an empty stack it is a plain push.
  always_comb begin
    empty      = (depth == '0);
    full       = (depth == (AW+1)'(DEPTH));
    do_replace = push & pop & ~empty;
    do_push    = push & ~do_replace & ~full;
    ovf_hit    = push & ~do_replace & full;
    do_pop     = pop & ~push & ~empty;
    unf_hit    = pop & ~push & empty;
    wr_en      = (do_replace | do_push) & ~clear;
    wptr       = do_replace ? (depth - (AW+1)'(1)) : depth;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      depth         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else if (clear) begin
      depth         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (do_push) begin
        depth <= depth + (AW+1)'(1);
      end else if (do_pop) begin
        depth <= depth - (AW+1)'(1);
      end
      if (ovf_hit) err_overflow <= 1'b1;
      if (unf_hit) err_underflow <= 1'b1;
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maze_move_replay.sv
// Records the solver's DFS move stack and replays the final path one move per step interval.
// Optional pause/resume of a replay via `run` is enabled by MAZE_REPLAY_PAUSE_EN.
module maze_move_replay
  import maze_pkg::*;
#(
  parameter int unsigned DEPTH       = MAZE_CELLS,
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned AW          = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        push,
  input  logic        pop,
  input  logic [1:0]  move_in,
  input  logic        solve_done,
  input  logic        solve_fail,
  input  logic        run,
  output logic [1:0]  move_out,
  output logic        move_valid,
  output logic        path_ready,
  output logic        replay_busy,
  output logic        replay_done,
  output logic [AW:0] depth,
  output logic        err_overflow,
  output logic        err_underflow
);

  localparam int unsigned   SW          = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SW-1:0] STEP_RELOAD = SW'(STEP_CYCLES - 1);

  replay_state_t state, state_n;
  logic [AW:0]   idx, idx_n;
  logic [SW-1:0] step, step_n;
  logic [1:0]    move_out_n;
  logic          move_valid_n;
  logic          replay_done_n;
  logic          replay_busy_n;
  logic          path_ready_n;
  logic          collecting;
  move_t         rd_move;

  assign collecting = (state == COLLECT) & ~start;

  move_stack #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_stack (
    .clk           (clk),
    .rst           (rst),
    .clear         (start),
    .push          (push & collecting),
    .pop           (pop & collecting),
    .wdata         (move_t'(move_in)),
    .raddr         (idx[AW-1:0]),
    .rdata         (rd_move),
    .depth         (depth),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      step        <= '0;
      move_out    <= 2'b00;
      move_valid  <= 1'b0;
      replay_done <= 1'b0;
      replay_busy <= 1'b0;
      path_ready  <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      step        <= step_n;
      move_out    <= move_out_n;
      move_valid  <= move_valid_n;
      replay_done <= replay_done_n;
      replay_busy <= replay_busy_n;
      path_ready  <= path_ready_n;
    end
  end

  always_comb begin
    state_n       = state;
    idx_n         = idx;
    step_n        = step;
    move_out_n    = move_out;
    move_valid_n  = 1'b0;
    replay_done_n = 1'b0;

    case (state)
      IDLE: ;
      COLLECT: begin
        if (solve_fail) begin
          state_n = IDLE;
        end else if (solve_done) begin
          state_n = (err_overflow | err_underflow) ? IDLE : READY;
        end
      end
      READY: begin
        if (run) begin
          state_n = PLAY;
          idx_n   = '0;
          step_n  = '0;
        end
      end
      PLAY: begin
`ifdef MAZE_REPLAY_PAUSE_EN
        if (run) begin
          state_n = PAUSE;
        end else
`endif
        if (idx == depth) begin
          state_n       = READY;
          replay_done_n = 1'b1;
        end else if (step == '0) begin
          move_out_n   = rd_move;
          move_valid_n = 1'b1;
          idx_n        = idx + (AW+1)'(1);
          step_n       = STEP_RELOAD;
        end else begin
          step_n = step - SW'(1);
        end
      end
`ifdef MAZE_REPLAY_PAUSE_EN
      // Resume strobes the next move on the following cycle.
      PAUSE: begin
        if (run) begin
          state_n = PLAY;
          step_n  = '0;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    if (start) begin
      state_n       = COLLECT;
      idx_n         = '0;
      step_n        = '0;
      move_valid_n  = 1'b0;
      replay_done_n = 1'b0;
    end

`ifdef MAZE_REPLAY_PAUSE_EN
    replay_busy_n = (state_n == PLAY) | (state_n == PAUSE);
`else
    replay_busy_n = (state_n == PLAY);
`endif
    path_ready_n = (state_n == READY) | replay_busy_n;
  end

endmodule

// File: tb/tb_maze_move_replay.sv
// Scoreboard bench for maze_move_replay: stimulus queues expected strobes, a monitor checks them.
// The mid-replay `run` scenario follows MAZE_REPLAY_PAUSE_EN.
module tb_maze_move_replay;

  logic       clk;
  logic       rst;
  logic       start;
  logic       push;
  logic       pop;
  logic [1:0] move_in;
  logic       solve_done;
  logic       solve_fail;
  logic       run;
  logic [1:0] move_out;
  logic       move_valid;
  logic       path_ready;
  logic       replay_busy;
  logic       replay_done;
  logic [8:0] depth;
  logic       err_overflow;
  logic       err_underflow;

  maze_move_replay dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .push          (push),
    .pop           (pop),
    .move_in       (move_in),
    .solve_done    (solve_done),
    .solve_fail    (solve_fail),
    .run           (run),
    .move_out      (move_out),
    .move_valid    (move_valid),
    .path_ready    (path_ready),
    .replay_busy   (replay_busy),
    .replay_done   (replay_done),
    .depth         (depth),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  typedef struct {
    bit         is_done;
    logic [1:0] mv;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the expectation queue in value and cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      if (move_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_move got move %0d at cycle %0d required no strobe", move_out, cyc);
        end else begin
          e = q.pop_front();
          if (e.is_done || move_out !== e.mv || cyc != e.cyc) begin
            errors++;
            $display("FAIL move_strobe got move %0d at cycle %0d required %s %0d at cycle %0d",
                     move_out, cyc, e.is_done ? "done" : "move", e.mv, e.cyc);
          end
        end
      end
      if (replay_done) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done got replay_done at cycle %0d required no strobe", cyc);
        end else begin
          e = q.pop_front();
          if (!e.is_done || cyc != e.cyc) begin
            errors++;
            $display("FAIL done_strobe got done at cycle %0d required %s at cycle %0d",
                     cyc, e.is_done ? "done" : "move", e.cyc);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic do_op(input logic p, input logic o, input logic [1:0] mv);
    push = p; pop = o; move_in = mv;
    step();
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_done();
    solve_done = 1'b1; step(); solve_done = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1; step(); run = 1'b0;
  endtask

  task automatic exp_move(input logic [1:0] mv, input int c);
    exp_t e;
    e.is_done = 1'b0; e.mv = mv; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic exp_done(input int c);
    exp_t e;
    e.is_done = 1'b1; e.mv = 2'b00; e.cyc = c;
    q.push_back(e);
  endtask

  // Queues the whole expected replay (STEP_CYCLES=4) and issues run; returns sample edge k.
  task automatic issue_replay(input int n, input logic [1:0] mv [4], output int k);
    k = cyc + 1;
    for (int i = 0; i < n; i++) exp_move(mv[i], k + 1 + 4 * i);
    exp_done((n == 0) ? k + 1 : k + 4 * n - 2);
    pulse_run();
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 200;
    while (q.size() > 0 && budget > 0) begin
      step();
      budget--;
    end
    chk({name, "_drain_left"}, q.size(), 0);
    q.delete();
    step();
  endtask

  task automatic step_to(input int c);
    int budget;
    budget = 200;
    while (cyc < c && budget > 0) begin
      step();
      budget--;
    end
  endtask

  initial begin
    logic [1:0] path [4];
    int k;

    rst = 1'b0; start = 1'b0; push = 1'b0; pop = 1'b0; move_in = 2'b00;
    solve_done = 1'b0; solve_fail = 1'b0; run = 1'b0;
    #12;
    chk("rst_move_valid", move_valid, 0);
    chk("rst_path_ready", path_ready, 0);
    chk("rst_busy", replay_busy, 0);
    chk("rst_done", replay_done, 0);
    chk("rst_depth", depth, 0);
    chk("rst_ovf", err_overflow, 0);
    chk("rst_unf", err_underflow, 0);
    chk("rst_move_out", move_out, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    step();

    // Basic record with a backtrack, then two identical replays.
    pulse_start();
    do_op(1, 0, 2'b00);
    do_op(1, 0, 2'b01);
    do_op(1, 0, 2'b01);
    do_op(1, 0, 2'b10);
    do_op(0, 1, 2'b00);
    do_op(1, 0, 2'b11);
    chk("basic_depth", depth, 4);
    pulse_done();
    chk("basic_path_ready", path_ready, 1);
    path[0] = 2'b00; path[1] = 2'b01; path[2] = 2'b01; path[3] = 2'b11;
    issue_replay(4, path, k);
    chk("play_busy", replay_busy, 1);
    drain("replay1");
    chk("after_busy", replay_busy, 0);
    chk("after_path_ready", path_ready, 1);
    issue_replay(4, path, k);
    drain("replay2");
    chk("replay2_depth", depth, 4);

    // Overflow: 257 pushes, then solve_done falls back to IDLE.
    pulse_start();
    for (int i = 0; i < 257; i++) do_op(1, 0, 2'(i));
    chk("ovf_depth", depth, 256);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_unf_flag", err_underflow, 0);
    pulse_done();
    chk("ovf_path_ready", path_ready, 0);
    pulse_run();
    step_n(10);
    chk("ovf_busy", replay_busy, 0);

    // Simultaneous done and fail: fail wins.
    pulse_start();
    chk("start_clears_ovf", err_overflow, 0);
    do_op(1, 0, 2'b10);
    do_op(1, 0, 2'b01);
    solve_done = 1'b1; solve_fail = 1'b1;
    step();
    solve_done = 1'b0; solve_fail = 1'b0;
    chk("fail_path_ready", path_ready, 0);
    chk("fail_depth", depth, 2);
    pulse_run();
    step_n(10);
    chk("fail_busy", replay_busy, 0);

    // Underflow, then push+pop on empty and non-empty stacks.
    pulse_start();
    do_op(0, 1, 2'b00);
    chk("unf_flag", err_underflow, 1);
    chk("unf_depth", depth, 0);
    pulse_start();
    chk("start_clears_unf", err_underflow, 0);
    do_op(1, 1, 2'b11);
    chk("pp_empty_depth", depth, 1);
    do_op(1, 0, 2'b00);
    do_op(1, 1, 2'b10);
    chk("pp_replace_depth", depth, 2);
    pulse_done();
    chk("pp_path_ready", path_ready, 1);
    path[0] = 2'b11; path[1] = 2'b10;
    issue_replay(2, path, k);
    drain("replace");

    // Empty path: replay_done only.
    pulse_start();
    pulse_done();
    chk("empty_path_ready", path_ready, 1);
    issue_replay(0, path, k);
    drain("empty");

    // start at the second move aborts the replay.
    pulse_start();
    do_op(1, 0, 2'b01);
    do_op(1, 0, 2'b10);
    do_op(1, 0, 2'b11);
    pulse_done();
    k = cyc + 1;
    exp_move(2'b01, k + 1);
    pulse_run();
    step_to(k + 4);
    pulse_start();
    chk("abort_move_valid", move_valid, 0);
    chk("abort_busy", replay_busy, 0);
    chk("abort_path_ready", path_ready, 0);
    chk("abort_depth", depth, 0);
    step_n(10);
    chk("abort_queue_left", q.size(), 0);
    q.delete();

    // Mid-replay run: pause/resume when enabled, ignored otherwise.
    do_op(1, 0, 2'b00);
    do_op(1, 0, 2'b11);
    pulse_done();
    k = cyc + 1;
    exp_move(2'b00, k + 1);
`ifdef MAZE_REPLAY_PAUSE_EN
    exp_move(2'b11, k + 23);
    exp_done(k + 24);
`else
    exp_move(2'b11, k + 5);
    exp_done(k + 6);
`endif
    pulse_run();
    step_to(k + 1);
    pulse_run();
`ifdef MAZE_REPLAY_PAUSE_EN
    step_n(5);
    chk("pause_busy", replay_busy, 1);
    step_to(k + 21);
    pulse_run();
`endif
    drain("midrun");

    chk("final_queue", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
